// File: rtl/cavlc_pkg.sv
// Shared CAVLC definitions: count limits, code-word field positions, request/beat payloads
// and the TotalCoeff/TotalZeros classification used by the total_zeros scheduler.
package cavlc_pkg;

    localparam int unsigned TC_MAX    = 16;
    localparam int unsigned TZ_ADDR_W = 4;
    localparam int unsigned VAL_MSB   = 6;
    localparam int unsigned LEN_MSB   = 3;
    localparam int unsigned CNT_W     = 5;
    localparam int unsigned BITS_W    = 9;
    localparam int unsigned REQ_TAG_W = 4;

    typedef enum logic [1:0] {
        CLS_SKIP,
        CLS_ILLEGAL,
        CLS_LEGAL
    } tz_class_e;

    typedef struct packed {
        logic [CNT_W-1:0]     tc;
        logic [CNT_W-1:0]     tz;
        logic [REQ_TAG_W-1:0] tag;
    } tz_req_t;

    typedef struct packed {
        logic [BITS_W-1:0]    bits;
        logic [LEN_MSB:0]     len;
        logic                 src;
        logic [REQ_TAG_W-1:0] tag;
    } tz_beat_t;

    // Blocks with no coefficients or all coefficients nonzero carry no total_zeros code.
    function automatic tz_class_e classify(input logic [CNT_W-1:0] tc, input logic [CNT_W-1:0] tz);
        if (tc == '0 || tc == CNT_W'(TC_MAX)) begin
            return CLS_SKIP;
        end
        if (tc > CNT_W'(TC_MAX) || tz > CNT_W'(TC_MAX) || tz > (CNT_W'(TC_MAX) - tc)) begin
            return CLS_ILLEGAL;
        end
        return CLS_LEGAL;
    endfunction

    function automatic logic [2*TZ_ADDR_W-1:0] rom_index(input logic [CNT_W-1:0] tc,
                                                         input logic [CNT_W-1:0] tz);
        logic [CNT_W-1:0] tcm1;
        tcm1 = tc - CNT_W'(1);
        return {tcm1[TZ_ADDR_W-1:0], tz[TZ_ADDR_W-1:0]};
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; after a grant the pointer moves to the other requester.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt_c
);

    logic ptr;

    always_comb begin
        gnt_c = 2'b00;
        if (en) begin
            if (&req) begin
                gnt_c[ptr] = 1'b1;
            end else begin
                gnt_c = req;
            end
        end
    end

    // Every grant is a completed handshake, so the pointer follows grants directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (|gnt_c) begin
            ptr <= ~gnt_c[1];
        end
    end

endmodule

// File: rtl/total_zeros_sched.sv
// Shares one Total_Zeros_Enc ROM between two CAVLC lanes: stage A registers the ROM
// address, stage B registers the returned {code, length} as the output beat.
module total_zeros_sched
    import cavlc_pkg::*;
#(
    parameter int unsigned aWIDTH   = 8,
    parameter int unsigned tzcWIDTH = 7,
    parameter int unsigned TAG_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0][CNT_W-1:0] req_tc,
    input  logic [1:0][CNT_W-1:0] req_tz,
    input  logic [1:0][TAG_W-1:0] req_tag,
    output logic [aWIDTH-1:0]     rom_addr,
    input  logic [tzcWIDTH-1:0]   rom_code,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BITS_W-1:0]     out_bits,
    output logic [LEN_MSB:0]      out_len,
    output logic                  out_src,
    output logic [TAG_W-1:0]      out_tag,
    output logic                  err_pulse
);

    logic [1:0]           gnt;
    logic                 acc;
    logic                 acc_src;
    tz_req_t              sel;
    tz_class_e            cls;
    logic                 b_adv;
    logic                 a_free;
    logic                 a_valid;
    logic [aWIDTH-1:0]    a_addr;
    logic                 a_src;
    logic [REQ_TAG_W-1:0] a_tag;
    tz_beat_t             b_q;

    assign b_adv  = !out_valid || out_ready;
    assign a_free = !a_valid || b_adv;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (req_valid),
        .en    (a_free && !rst),
        .gnt_c (gnt)
    );

    assign req_ready = gnt;

    // Mux the granted request and classify it.
    always_comb begin
        acc     = |gnt;
        acc_src = gnt[1];
        sel.tc  = req_tc[acc_src];
        sel.tz  = req_tz[acc_src];
        sel.tag = REQ_TAG_W'(req_tag[acc_src]);
        cls     = classify(sel.tc, sel.tz);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid   <= 1'b0;
            a_addr    <= '0;
            a_src     <= 1'b0;
            a_tag     <= '0;
            out_valid <= 1'b0;
            b_q       <= '0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= acc && (cls == CLS_ILLEGAL);
            if (a_free) begin
                a_valid <= acc && (cls == CLS_LEGAL);
                if (acc && (cls == CLS_LEGAL)) begin
                    a_addr <= aWIDTH'(rom_index(sel.tc, sel.tz));
                    a_src  <= acc_src;
                    a_tag  <= sel.tag;
                end
            end
            // Stage B samples the combinational ROM word addressed by stage A.
            if (b_adv) begin
                out_valid <= a_valid;
                if (a_valid) begin
                    b_q.bits <= BITS_W'(rom_code[VAL_MSB:LEN_MSB+1]);
                    b_q.len  <= rom_code[LEN_MSB:0];
                    b_q.src  <= a_src;
                    b_q.tag  <= a_tag;
                end
            end
        end
    end

    assign rom_addr = a_addr;
    assign out_bits = b_q.bits;
    assign out_len  = b_q.len;
    assign out_src  = b_q.src;
    assign out_tag  = TAG_W'(b_q.tag);

endmodule

// File: tb/tb_total_zeros_sched.sv
// Bench for total_zeros_sched: a ROM image, a negedge scoreboard built from the request
// classification rules, and directed plus randomized scenarios.
module tb_total_zeros_sched;

    logic            clk;
    logic            rst;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [1:0][4:0] req_tc;
    logic [1:0][4:0] req_tz;
    logic [1:0][3:0] req_tag;
    logic [7:0]      rom_addr;
    logic [6:0]      rom_code;
    logic            out_valid;
    logic            out_ready;
    logic [8:0]      out_bits;
    logic [3:0]      out_len;
    logic            out_src;
    logic [3:0]      out_tag;
    logic            err_pulse;

    logic [6:0]  rom [256];
    logic [17:0] exp_q[$];
    logic        pend_err;
    int          n_checks;
    int          n_fail;

    assign rom_code = rom[rom_addr];

    total_zeros_sched dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_tc    (req_tc),
        .req_tz    (req_tz),
        .req_tag   (req_tag),
        .rom_addr  (rom_addr),
        .rom_code  (rom_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bits  (out_bits),
        .out_len   (out_len),
        .out_src   (out_src),
        .out_tag   (out_tag),
        .err_pulse (err_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: expected beats are queued at acceptance from the ROM image.
    always @(negedge clk) begin : mon
        int          tc;
        int          tz;
        logic [6:0]  w;
        logic [17:0] e;
        if (rst) begin
            exp_q.delete();
            pend_err = 1'b0;
        end else begin
            n_checks++;
            if (err_pulse !== pend_err) begin
                n_fail++;
                $display("FAIL err_pulse @%0t: got %b expected %b", $time, err_pulse, pend_err);
            end
            pend_err = 1'b0;
            n_checks++;
            if (req_ready == 2'b11) begin
                n_fail++;
                $display("FAIL one_grant @%0t: got req_ready=%b expected at most one bit", $time, req_ready);
            end
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    tc = int'(req_tc[i]);
                    tz = int'(req_tz[i]);
                    if (tc == 0 || tc == 16) begin
                        pend_err = pend_err;
                    end else if (tc > 16 || tz > 16 || tc + tz > 16) begin
                        pend_err = 1'b1;
                    end else begin
                        w = rom[8'((tc - 1) * 16 + tz)];
                        e = {6'd0, w[6:4], w[3:0], 1'(i), req_tag[i]};
                        exp_q.push_back(e);
                    end
                end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_beat @%0t: got beat %h expected none", $time,
                             {out_bits, out_len, out_src, out_tag});
                end else begin
                    e = exp_q.pop_front();
                    if ({out_bits, out_len, out_src, out_tag} !== e) begin
                        n_fail++;
                        $display("FAIL beat @%0t: got %h expected %h", $time,
                                 {out_bits, out_len, out_src, out_tag}, e);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        req_valid = '0;
        out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic load_legal(input int i);
        int tc;
        tc         = int'($urandom_range(15, 1));
        req_tc[i]  = 5'(tc);
        req_tz[i]  = 5'($urandom_range(16 - tc, 0));
        req_tag[i] = 4'($urandom_range(15, 0));
    endtask

    task automatic wait_drain(output int left);
        for (int n = 0; n < 40 && exp_q.size() != 0; n++) step();
        left = exp_q.size();
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        out_ready = 1'b1;
        req_valid = 2'b11;
        load_legal(0);
        load_legal(1);
        step();
        #1;
        n_checks++;
        if (req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_ready: got %b expected 00", req_ready); end
        step();
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        n_checks++;
        if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b expected 0", err_pulse); end
        n_checks++;
        if ({out_bits, out_len, out_src, out_tag} !== 18'd0) begin
            n_fail++;
            $display("FAIL rst_beat: got %h expected 0", {out_bits, out_len, out_src, out_tag});
        end
        n_checks++;
        if (rom_addr !== 8'd0) begin n_fail++; $display("FAIL rst_addr: got %h expected 00", rom_addr); end
        req_valid = '0;
        rst       = 1'b0;
    endtask

    task automatic test_single();
        apply_reset();
        req_valid  = 2'b01;
        req_tc[0]  = 5'd1;
        req_tz[0]  = 5'd0;
        req_tag[0] = 4'd5;
        #1;
        n_checks++;
        if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single_grant: got %b expected 01", req_ready); end
        step();
        req_valid = '0;
        #1;
        n_checks++;
        if ({out_valid, rom_addr} !== {1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL single_n1: got valid=%b addr=%h expected 0/00", out_valid, rom_addr);
        end
        step();
        #1;
        n_checks++;
        if ({out_valid, out_bits, out_len, out_src, out_tag} !== {1'b1, 9'd1, 4'd1, 1'b0, 4'd5}) begin
            n_fail++;
            $display("FAIL single_n2: got v=%b bits=%0d len=%0d src=%b tag=%0d expected 1/1/1/0/5",
                     out_valid, out_bits, out_len, out_src, out_tag);
        end
        step();
    endtask

    task automatic test_pair();
        apply_reset();
        req_valid  = 2'b11;
        req_tc[0]  = 5'd3;
        req_tz[0]  = 5'd6;
        req_tag[0] = 4'd1;
        req_tc[1]  = 5'd2;
        req_tz[1]  = 5'd14;
        req_tag[1] = 4'd2;
        #1;
        n_checks++;
        if (req_ready !== 2'b01) begin n_fail++; $display("FAIL pair_grant0: got %b expected 01", req_ready); end
        step();
        req_valid[0] = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 2'b10) begin n_fail++; $display("FAIL pair_grant1: got %b expected 10", req_ready); end
        n_checks++;
        if (rom_addr !== 8'h26) begin n_fail++; $display("FAIL pair_addr: got %h expected 26", rom_addr); end
        step();
        req_valid = '0;
        #1;
        n_checks++;
        if ({out_valid, out_bits, out_len, out_src, out_tag} !== {1'b1, 9'd4, 4'd3, 1'b0, 4'd1}) begin
            n_fail++;
            $display("FAIL pair_beat0: got v=%b bits=%0d len=%0d src=%b tag=%0d expected 1/4/3/0/1",
                     out_valid, out_bits, out_len, out_src, out_tag);
        end
        step();
        #1;
        n_checks++;
        if ({out_valid, out_bits, out_len, out_src, out_tag} !== {1'b1, 9'd0, 4'd6, 1'b1, 4'd2}) begin
            n_fail++;
            $display("FAIL pair_beat1: got v=%b bits=%0d len=%0d src=%b tag=%0d expected 1/0/6/1/2",
                     out_valid, out_bits, out_len, out_src, out_tag);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [1:0] want;
        apply_reset();
        load_legal(0);
        load_legal(1);
        req_valid = 2'b11;
        for (int k = 0; k < 10; k++) begin
            if (k >= 8) req_valid = '0;
            #1;
            if (k < 8) begin
                want = (k % 2 == 0) ? 2'b01 : 2'b10;
                n_checks++;
                if (req_ready !== want) begin
                    n_fail++;
                    $display("FAIL b2b_grant k=%0d: got %b expected %b", k, req_ready, want);
                end
            end
            if (k >= 2) begin
                n_checks++;
                if (out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_throughput k=%0d: got out_valid=%b expected 1", k, out_valid);
                end
            end
            step();
            if (k < 8) load_legal(k % 2);
        end
    endtask

    task automatic test_skip_illegal();
        logic [5:0] err_h;
        logic [5:0] ov_h;
        apply_reset();
        req_valid  = 2'b01;
        req_tc[0]  = 5'd0;
        req_tz[0]  = 5'd3;
        req_tag[0] = 4'd1;
        for (int c = 0; c < 6; c++) begin
            #1;
            err_h[c] = err_pulse;
            ov_h[c]  = out_valid;
            if (c < 3) begin
                n_checks++;
                if (req_ready !== 2'b01) begin
                    n_fail++;
                    $display("FAIL skip_ack c=%0d: got %b expected 01", c, req_ready);
                end
            end
            step();
            if (c == 0) begin
                req_tc[0] = 5'd16;
                req_tz[0] = 5'd0;
            end else if (c == 1) begin
                req_tc[0] = 5'd5;
                req_tz[0] = 5'd12;
            end else if (c == 2) begin
                req_valid = '0;
            end
        end
        n_checks++;
        if (err_h !== 6'b001000) begin n_fail++; $display("FAIL skip_err_hist: got %b expected 001000", err_h); end
        n_checks++;
        if (ov_h !== 6'b000000) begin n_fail++; $display("FAIL skip_no_beat: got %b expected 000000", ov_h); end
    endtask

    task automatic test_backpressure();
        logic [17:0] snap;
        logic        got;
        int          acc_n;
        int          left;
        apply_reset();
        out_ready = 1'b0;
        acc_n     = 0;
        snap      = '0;
        req_valid = 2'b01;
        load_legal(0);
        for (int c = 0; c < 5; c++) begin
            #1;
            if (c == 2) begin
                snap = {out_bits, out_len, out_src, out_tag};
                n_checks++;
                if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b expected 1", out_valid); end
            end
            if (c > 2) begin
                n_checks++;
                if ({out_valid, out_bits, out_len, out_src, out_tag} !== {1'b1, snap}) begin
                    n_fail++;
                    $display("FAIL bp_stable c=%0d: got %h expected %h", c,
                             {out_valid, out_bits, out_len, out_src, out_tag}, {1'b1, snap});
                end
            end
            if (c == 4) begin
                n_checks++;
                if (req_ready !== 2'b00) begin n_fail++; $display("FAIL bp_ready: got %b expected 00", req_ready); end
            end
            got = req_ready[0];
            step();
            if (got) begin
                acc_n++;
                load_legal(0);
            end
        end
        n_checks++;
        if (acc_n != 2) begin n_fail++; $display("FAIL bp_held: got %0d accepts expected 2", acc_n); end
        out_ready = 1'b1;
        for (int n = 0; n < 20 && acc_n < 4; n++) begin
            #1;
            got = req_ready[0];
            step();
            if (got) begin
                acc_n++;
                if (acc_n == 4) req_valid = '0;
                else load_legal(0);
            end
        end
        req_valid = '0;
        wait_drain(left);
        n_checks++;
        if (acc_n != 4 || left != 0) begin
            n_fail++;
            $display("FAIL bp_drain: got accepts=%0d pending=%0d expected 4/0", acc_n, left);
        end
    endtask

    task automatic test_reset_midflight();
        logic got;
        int   left;
        apply_reset();
        out_ready = 1'b0;
        req_valid = 2'b01;
        load_legal(0);
        for (int c = 0; c < 3; c++) begin
            #1;
            got = req_ready[0];
            step();
            if (got) load_legal(0);
        end
        req_valid = 2'b11;
        load_legal(1);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, req_ready} !== 3'b100) begin
            n_fail++;
            $display("FAIL mid_full: got valid=%b ready=%b expected 1/00", out_valid, req_ready);
        end
        step();
        rst = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_flush: got out_valid=%b expected 0", out_valid); end
        n_checks++;
        if (req_ready !== 2'b01) begin n_fail++; $display("FAIL mid_ptr: got %b expected 01", req_ready); end
        step();
        req_valid = '0;
        out_ready = 1'b1;
        wait_drain(left);
        n_checks++;
        if (left != 0) begin n_fail++; $display("FAIL mid_drain: got %0d pending expected 0", left); end
    endtask

    task automatic test_random();
        logic [1:0] acc;
        int         left;
        apply_reset();
        for (int c = 0; c < 300; c++) begin
            out_ready = ($urandom_range(3, 0) != 0);
            for (int i = 0; i < 2; i++) begin
                if (!req_valid[i] && $urandom_range(1, 0) == 1) begin
                    req_valid[i] = 1'b1;
                    if ($urandom_range(1, 0) == 1) begin
                        load_legal(i);
                    end else begin
                        req_tc[i]  = 5'($urandom_range(18, 0));
                        req_tz[i]  = 5'($urandom_range(18, 0));
                        req_tag[i] = 4'($urandom_range(15, 0));
                    end
                end
            end
            #1;
            acc = req_valid & req_ready;
            step();
            req_valid = req_valid & ~acc;
        end
        req_valid = '0;
        out_ready = 1'b1;
        wait_drain(left);
        n_checks++;
        if (left != 0) begin n_fail++; $display("FAIL rand_drain: got %0d pending expected 0", left); end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        pend_err  = 1'b0;
        rst       = 1'b1;
        out_ready = 1'b1;
        req_valid = '0;
        req_tc    = '0;
        req_tz    = '0;
        req_tag   = '0;
        for (int a = 0; a < 256; a++) rom[a] = 7'($urandom_range(127, 0));
        rom[8'h00] = 7'h11;
        rom[8'h26] = 7'h43;
        rom[8'h1E] = 7'h06;
        test_reset();
        test_single();
        test_pair();
        test_back_to_back();
        test_skip_illegal();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
